// File: rtl/jogo_pkg.sv
// Shared definitions for the board read path.
//   celula_t        : 2-bit cell code stored in ram_board
//   ASCII_*         : bytes emitted on the board stream
//   estado_t        : states of leitor_tabuleiro
//   rc_para_one_hot : screen (row, col) -> {one-hot macro, one-hot micro}
package jogo_pkg;

  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    JOG_X = 2'b01,
    JOG_O = 2'b10,
    BLOQ  = 2'b11
  } celula_t;

  localparam logic [7:0] ASCII_VAZIO    = 8'h2E;
  localparam logic [7:0] ASCII_X        = 8'h58;
  localparam logic [7:0] ASCII_O        = 8'h4F;
  localparam logic [7:0] ASCII_BLOQ     = 8'h23;
  localparam logic [7:0] ASCII_DESTAQUE = 8'h2A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

  localparam logic [3:0] ULTIMO_IDX = 4'd8;

  typedef enum logic [2:0] {
    OCIOSO,
    ENDERECA,
    ESPERA,
    ENVIA,
    ENVIA_CR,
    ENVIA_LF,
    FIM
  } estado_t;

  // The board is 3x3 macro-boards of 3x3 cells each; screen rows/cols
  // split into a macro coordinate (/3) and a position inside it (%3).
  function automatic logic [17:0] rc_para_one_hot(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] idx_macro;
    logic [3:0] idx_micro;
    idx_macro = (r / 4'd3) * 4'd3 + c / 4'd3;
    idx_micro = (r % 4'd3) * 4'd3 + c % 4'd3;
    return {9'b000000001 << idx_macro, 9'b000000001 << idx_micro};
  endfunction

endpackage

// File: rtl/conversor_celula.sv
// Combinational cell-code to ASCII conversion.
//   q        in  2  cell code (VAZIO, JOG_X, JOG_O, BLOQ)
//   destaque in  1  empty cell lies in the highlighted macro-board
//   ascii    out 8  byte to stream
module conversor_celula
  import jogo_pkg::*;
(
  input  logic [1:0] q,
  input  logic       destaque,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_VAZIO;
    case (q)
      VAZIO:   ascii = destaque ? ASCII_DESTAQUE : ASCII_VAZIO;
      JOG_X:   ascii = ASCII_X;
      JOG_O:   ascii = ASCII_O;
      BLOQ:    ascii = ASCII_BLOQ;
      default: ascii = ASCII_VAZIO;
    endcase
  end

endmodule

// File: rtl/leitor_tabuleiro.sv
// Board reader: scans ram_board in screen row-major order and streams
// the board as ASCII over a valid/ready byte interface.
//   clock        in   1  rising-edge clock
//   reset        in   1  asynchronous, active-high
//   iniciar      in   1  start request, honoured only while idle
//   addr_macro   out  9  one-hot macro-board select
//   addr_micro   out  9  one-hot cell select
//   q            in   2  cell code read back from ram_board
//   macro_atual  in   9  one-hot highlighted macro (only with HIGHLIGHT_EN)
//   dado         out  8  ASCII byte
//   dado_valido  out  1  dado holds a byte
//   dado_pronto  in   1  sink accepts dado this edge
//   ocupado      out  1  frame in progress
//   pronto       out  1  one-cycle pulse after the last byte of a frame
// Build option: define HIGHLIGHT_EN to add macro_atual; empty cells inside
// that macro then stream as '*'.
//
// state    | meaning
// OCIOSO   | idle, waiting for iniciar
// ENDERECA | drive one-hot address for cell (r,c)
// ESPERA   | wait for ram_board read latency
// ENVIA    | cell byte presented, waiting for transfer
// ENVIA_CR | carriage return presented
// ENVIA_LF | line feed presented
// FIM      | frame done, pronto pulse
module leitor_tabuleiro
  import jogo_pkg::*;
#(
  parameter int LATENCIA_RAM = 1,
  parameter bit LINHA_FIM    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  output logic [8:0] addr_macro,
  output logic [8:0] addr_micro,
  input  logic [1:0] q,
`ifdef HIGHLIGHT_EN
  input  logic [8:0] macro_atual,
`endif
  output logic [7:0] dado,
  output logic       dado_valido,
  input  logic       dado_pronto,
  output logic       ocupado,
  output logic       pronto
);

  estado_t     estado, estado_prox;
  logic [3:0]  r, r_prox;
  logic [3:0]  c, c_prox;
  logic [7:0]  cnt_espera, cnt_espera_prox;
  logic [7:0]  dado_prox;
  logic        valido_prox;
  logic [8:0]  macro_prox, micro_prox;
  logic        transfere;
  logic        fecha_linha;
  logic        destaque;
  logic [7:0]  ascii_celula;

`ifdef HIGHLIGHT_EN
  assign destaque = |(addr_macro & macro_atual);
`else
  assign destaque = 1'b0;
`endif

  conversor_celula u_conversor (
    .q        (q),
    .destaque (destaque),
    .ascii    (ascii_celula)
  );

  assign transfere = dado_valido & dado_pronto;
  assign ocupado   = (estado != OCIOSO);
  assign pronto    = (estado == FIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      r           <= 4'd0;
      c           <= 4'd0;
      cnt_espera  <= 8'd0;
      dado        <= 8'h00;
      dado_valido <= 1'b0;
      addr_macro  <= 9'b000000001;
      addr_micro  <= 9'b000000001;
    end else begin
      estado      <= estado_prox;
      r           <= r_prox;
      c           <= c_prox;
      cnt_espera  <= cnt_espera_prox;
      dado        <= dado_prox;
      dado_valido <= valido_prox;
      addr_macro  <= macro_prox;
      addr_micro  <= micro_prox;
    end
  end

  always_comb begin
    estado_prox     = estado;
    r_prox          = r;
    c_prox          = c;
    cnt_espera_prox = cnt_espera;
    dado_prox       = dado;
    valido_prox     = dado_valido;
    macro_prox      = addr_macro;
    micro_prox      = addr_micro;
    fecha_linha     = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          r_prox      = 4'd0;
          c_prox      = 4'd0;
          estado_prox = ENDERECA;
        end
      end
      ENDERECA: begin
        {macro_prox, micro_prox} = rc_para_one_hot(r, c);
        cnt_espera_prox = 8'(LATENCIA_RAM);
        estado_prox     = ESPERA;
      end
      ESPERA: begin
        // Terminal count reached one cycle after the RAM latency expires,
        // which covers our own address register in front of ram_board.
        if (cnt_espera == 8'd0) begin
          dado_prox   = ascii_celula;
          valido_prox = 1'b1;
          estado_prox = ENVIA;
        end else begin
          cnt_espera_prox = cnt_espera - 8'd1;
        end
      end
      ENVIA: begin
        if (transfere) begin
          if (c != ULTIMO_IDX) begin
            c_prox      = c + 4'd1;
            valido_prox = 1'b0;
            estado_prox = ENDERECA;
          end else if (LINHA_FIM) begin
            // CR follows directly; valid stays high across CR and LF.
            dado_prox   = ASCII_CR;
            estado_prox = ENVIA_CR;
          end else begin
            fecha_linha = 1'b1;
          end
        end
      end
      ENVIA_CR: begin
        if (transfere) begin
          dado_prox   = ASCII_LF;
          estado_prox = ENVIA_LF;
        end
      end
      ENVIA_LF: begin
        if (transfere) fecha_linha = 1'b1;
      end
      FIM: begin
        estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase

    if (fecha_linha) begin
      valido_prox = 1'b0;
      c_prox      = 4'd0;
      if (r != ULTIMO_IDX) begin
        r_prox      = r + 4'd1;
        estado_prox = ENDERECA;
      end else begin
        estado_prox = FIM;
      end
    end
  end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
module tb_leitor_tabuleiro;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       iniciar_a = 1'b0, iniciar_b = 1'b0;
  logic       dado_pronto_a = 1'b1, dado_pronto_b = 1'b1;
  logic [8:0] am_a, ai_a, am_b, ai_b;
  logic [1:0] q_a = 2'b00, q_b = 2'b00, q_b_s1 = 2'b00;
  logic [7:0] dado_a, dado_b;
  logic       val_a, val_b, ocu_a, ocu_b, pr_a, pr_b;
  logic [8:0] macro_atual = 9'd0;

  logic [1:0] board [9][9];

  // A: default build (latency 1, CR/LF). B: latency 2, no line endings.
  leitor_tabuleiro #(.LATENCIA_RAM(1), .LINHA_FIM(1'b1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar_a),
    .addr_macro(am_a), .addr_micro(ai_a), .q(q_a),
`ifdef HIGHLIGHT_EN
    .macro_atual(macro_atual),
`endif
    .dado(dado_a), .dado_valido(val_a), .dado_pronto(dado_pronto_a),
    .ocupado(ocu_a), .pronto(pr_a)
  );

  leitor_tabuleiro #(.LATENCIA_RAM(2), .LINHA_FIM(1'b0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b),
    .addr_macro(am_b), .addr_micro(ai_b), .q(q_b),
`ifdef HIGHLIGHT_EN
    .macro_atual(macro_atual),
`endif
    .dado(dado_b), .dado_valido(val_b), .dado_pronto(dado_pronto_b),
    .ocupado(ocu_b), .pronto(pr_b)
  );

  function automatic int oh_idx(input logic [8:0] v);
    int k;
    k = 0;
    for (int i = 0; i < 9; i++) if (v[i]) k = i;
    return k;
  endfunction

  // ram_board models: q valid LATENCIA_RAM edges after the address changes.
  always @(posedge clock) begin
    q_a    <= board[oh_idx(am_a)][oh_idx(ai_a)];
    q_b_s1 <= board[oh_idx(am_b)][oh_idx(ai_b)];
    q_b    <= q_b_s1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int lat_obs, xfer_cyc;

  typedef struct {
    int         r;
    int         c;
    logic [1:0] codigo;
    logic [7:0] esperado;
  } vetor_t;
  vetor_t tabela [6];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
    end
  endtask

  task automatic limpa_tabuleiro();
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++) board[m][u] = 2'b00;
  endtask

  task automatic tabuleiro_aleatorio();
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++) board[m][u] = 2'($urandom_range(0, 3));
  endtask

  // Reference frame straight from the screen rules.
  task automatic model_frame(input bit lf, input logic [8:0] hl);
    int m, u;
    exp_q.delete();
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        m = (r / 3) * 3 + c / 3;
        u = (r % 3) * 3 + c % 3;
        case (board[m][u])
          2'b00:   exp_q.push_back(hl[m] ? 8'h2A : 8'h2E);
          2'b01:   exp_q.push_back(8'h58);
          2'b10:   exp_q.push_back(8'h4F);
          default: exp_q.push_back(8'h23);
        endcase
      end
      if (lf) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endtask

  task automatic cmp_frame(input string nome);
    chk({nome, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nome, got[i], exp_q[i]);
  endtask

  task automatic set_rdy(input bit sel, input bit v);
    if (sel) dado_pronto_b = v; else dado_pronto_a = v;
  endtask

  task automatic set_ini(input bit sel, input bit v);
    if (sel) iniciar_b = v; else iniciar_a = v;
  endtask

  // Starts a frame and collects it. Inputs are driven and outputs sampled on
  // the falling edge. abortar_em >= 0 stops (without reset) once that many
  // bytes have been accepted; cutucar_em >= 0 pulses iniciar at that byte.
  task automatic run_frame(input bit sel, input bit alterna, input int abortar_em,
                           input int cutucar_em, input int lat_esp);
    bit pv, pr, rdy, cutucou, fim, parar, v, p, o;
    logic [7:0] pd, d;
    int s;
    pv = 0; pr = 1; rdy = 1; cutucou = 0; fim = 0; parar = 0; pd = 8'h00;
    got.delete();
    lat_obs = -1;
    xfer_cyc = -1;
    @(negedge clock);
    set_rdy(sel, 1'b1);
    set_ini(sel, 1'b1);
    @(posedge clock);
    #1;
    s = cyc;
    set_ini(sel, 1'b0);
    for (int k = 0; k < 3000 && !fim && !parar; k++) begin
      @(negedge clock);
      v = sel ? val_b : val_a;
      d = sel ? dado_b : dado_a;
      p = sel ? pr_b : pr_a;
      o = sel ? ocu_b : ocu_a;
      if (lat_obs < 0 && v) lat_obs = cyc - s;
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, v}, 1);
        chk("hold_dado", {24'd0, d}, {24'd0, pd});
      end
      if (p) begin
        fim = 1;
        chk("pronto_after_last_byte", cyc, xfer_cyc + 1);
        chk("ocupado_during_pronto", {31'd0, o}, 1);
        @(negedge clock);
        chk("pronto_one_cycle", {31'd0, sel ? pr_b : pr_a}, 0);
        chk("ocupado_falls", {31'd0, sel ? ocu_b : ocu_a}, 0);
      end else begin
        if (cutucou) set_ini(sel, 1'b0);
        if (alterna) rdy = ~rdy;
        set_rdy(sel, rdy);
        if (v && rdy) begin
          got.push_back(d);
          xfer_cyc = cyc;
        end
        pv = v; pr = rdy; pd = d;
        if (cutucar_em >= 0 && !cutucou && got.size() == cutucar_em) begin
          set_ini(sel, 1'b1);
          cutucou = 1;
        end
        if (abortar_em >= 0 && got.size() == abortar_em) parar = 1;
      end
    end
    set_ini(sel, 1'b0);
    if (abortar_em < 0) begin
      chk("frame_completed", {31'd0, fim}, 1);
      chk("first_valid_latency", lat_obs, lat_esp);
    end
  endtask

  initial begin
    int idx;
    tabela[0] = '{4, 4, 2'b01, 8'h58};
    tabela[1] = '{0, 0, 2'b10, 8'h4F};
    tabela[2] = '{8, 8, 2'b11, 8'h23};
    tabela[3] = '{0, 8, 2'b01, 8'h58};
    tabela[4] = '{8, 0, 2'b10, 8'h4F};
    tabela[5] = '{3, 5, 2'b11, 8'h23};

    limpa_tabuleiro();
    repeat (3) @(negedge clock);
    chk("rst_macro_a", {23'd0, am_a}, 1);
    chk("rst_micro_a", {23'd0, ai_a}, 1);
    chk("rst_dado_a", {24'd0, dado_a}, 0);
    chk("rst_valid_a", {31'd0, val_a}, 0);
    chk("rst_ocupado_a", {31'd0, ocu_a}, 0);
    chk("rst_pronto_a", {31'd0, pr_a}, 0);
    chk("rst_valid_b", {31'd0, val_b}, 0);
    chk("rst_macro_b", {23'd0, am_b}, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Empty board, sink always ready: fixed text pattern.
    run_frame(0, 0, -1, -1, 3);
    chk("empty_len", got.size(), 99);
    for (int i = 0; i < got.size(); i++)
      chk("empty_byte", {24'd0, got[i]},
          (i % 11 == 9) ? 32'h0D : (i % 11 == 10) ? 32'h0A : 32'h2E);

    // Single marked cells at corners and interior.
    for (int t = 0; t < 6; t++) begin
      limpa_tabuleiro();
      board[(tabela[t].r / 3) * 3 + tabela[t].c / 3][(tabela[t].r % 3) * 3 + tabela[t].c % 3] = tabela[t].codigo;
      run_frame(0, 0, -1, -1, 3);
      idx = tabela[t].r * 11 + tabela[t].c;
      chk("table_byte", {24'd0, got[idx]}, {24'd0, tabela[t].esperado});
      model_frame(1'b1, macro_atual);
      cmp_frame("table_frame");
    end

    // Backpressure: ready toggling every cycle.
    limpa_tabuleiro();
    run_frame(0, 1, -1, -1, 3);
    model_frame(1'b1, macro_atual);
    cmp_frame("toggle_empty");

    // Random boards, with and without backpressure.
    for (int t = 0; t < 4; t++) begin
      tabuleiro_aleatorio();
      run_frame(0, t[0], -1, -1, 3);
      model_frame(1'b1, macro_atual);
      cmp_frame("random_frame");
    end

    // iniciar while busy is ignored; reset mid-frame aborts at once.
    tabuleiro_aleatorio();
    model_frame(1'b1, macro_atual);
    run_frame(0, 0, 30, 10, 3);
    reset = 1'b1;
    #1;
    chk("abort_valid", {31'd0, val_a}, 0);
    chk("abort_ocupado", {31'd0, ocu_a}, 0);
    chk("abort_pronto", {31'd0, pr_a}, 0);
    chk("abort_dado", {24'd0, dado_a}, 0);
    chk("abort_macro", {23'd0, am_a}, 1);
    chk("abort_prefix_len", got.size(), 30);
    for (int i = 0; i < 30 && i < got.size(); i++) chk("abort_prefix", {24'd0, got[i]}, {24'd0, exp_q[i]});
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_pronto", {31'd0, pr_a}, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    run_frame(0, 0, -1, -1, 3);
    cmp_frame("after_abort_frame");

    // No line endings, RAM latency 2.
    tabuleiro_aleatorio();
    run_frame(1, 0, -1, -1, 4);
    model_frame(1'b0, macro_atual);
    cmp_frame("nolf_frame");
    limpa_tabuleiro();
    run_frame(1, 1, -1, -1, 4);
    model_frame(1'b0, macro_atual);
    cmp_frame("nolf_toggle");

`ifdef HIGHLIGHT_EN
    limpa_tabuleiro();
    board[0][0] = 2'b10;
    macro_atual = 9'b000000001;
    run_frame(0, 0, -1, -1, 3);
    chk("hl_row0_c0", {24'd0, got[0]}, 32'h4F);
    chk("hl_row0_c1", {24'd0, got[1]}, 32'h2A);
    chk("hl_row1_c0", {24'd0, got[11]}, 32'h2A);
    chk("hl_row0_c3", {24'd0, got[3]}, 32'h2E);
    model_frame(1'b1, macro_atual);
    cmp_frame("hl_frame");
    tabuleiro_aleatorio();
    macro_atual = 9'b000010000;
    run_frame(0, 0, -1, -1, 3);
    model_frame(1'b1, macro_atual);
    cmp_frame("hl_random");
    macro_atual = 9'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
